// File: rtl/shift_chain_scheduler.sv
// Round-robin scheduler that serialises one WIDTH-bit word at a time from NREQ
// requesters onto a single MSB-first chain, with optional idle gap between frames.
module shift_chain_scheduler #(
  parameter int NREQ      = 4,
  parameter int LOG2NREQ  = 2,
  parameter int WIDTH     = 16,
  parameter int LOG2WIDTH = 4,
  parameter int GAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic                  enable_i,
  output logic                  data_o,
  output logic                  frame_o,
  output logic                  first_o,
  output logic [LOG2NREQ-1:0]   grant_id_o,
  output logic                  busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LOG2NREQ-1:0]  ptr_q, ptr_d;
  logic [LOG2NREQ-1:0]  grant_id_q, grant_id_d;
  logic [LOG2WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;

  logic                 grant_found;
  logic [LOG2NREQ-1:0]  grant_idx;
  logic [LOG2NREQ:0]    cand;
  logic                 grant;
  logic [LOG2NREQ-1:0]  next_ptr;
  logic [WIDTH-1:0]     cap_word;

  // Search upward from the pointer, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (LOG2NREQ+1)'(i);
      if (cand >= (LOG2NREQ+1)'(NREQ)) cand = cand - (LOG2NREQ+1)'(NREQ);
      if (!grant_found && req_valid_i[cand[LOG2NREQ-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[LOG2NREQ-1:0];
      end
    end
  end

  assign grant    = (state_q == ST_IDLE) && grant_found && !reset;
  assign next_ptr = (grant_idx == LOG2NREQ'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == LOG2NREQ'(k)) cap_word = req_data_i[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          shreg_d    = cap_word;
          grant_id_d = grant_idx;
          ptr_d      = next_ptr;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (enable_i) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (cnt_q == LOG2WIDTH'(WIDTH-1)) begin
            cnt_d     = '0;
            gap_cnt_d = '0;
            state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        // Gap length is fixed in cycles, so enable_i is deliberately ignored here.
        if (gap_cnt_q == 4'(GAP-1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign frame_o    = (state_q == ST_SHIFT) && !reset;
  assign data_o     = frame_o && shreg_q[WIDTH-1];
  assign first_o    = frame_o && (cnt_q == '0);
  assign busy_o     = (state_q != ST_IDLE) && !reset;
  assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_shift_chain_scheduler.sv
// Directed self-checking bench for shift_chain_scheduler: default instance
// (GAP=1) plus a GAP=0 instance for back-to-back frame spacing.
module tb_shift_chain_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        enable;
  logic        data_out, frame, first, busy;
  logic [1:0]  grant_id;

  logic [3:0]  v0;
  logic [63:0] d0;
  logic [3:0]  ready0;
  logic        data0, frame0, first0, busy0;
  logic [1:0]  grant_id0;

  int checks = 0;
  int errors = 0;
  logic [15:0] pat;
  logic [63:0] dword;

  shift_chain_scheduler dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .enable_i(enable), .data_o(data_out), .frame_o(frame),
    .first_o(first), .grant_id_o(grant_id), .busy_o(busy)
  );

  shift_chain_scheduler #(.GAP(0)) dut_g0 (
    .clk(clk), .reset(reset), .req_valid_i(v0), .req_data_i(d0),
    .req_ready_o(ready0), .enable_i(1'b1), .data_o(data0), .frame_o(frame0),
    .first_o(first0), .grant_id_o(grant_id0), .busy_o(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #2;
  endtask

  task applyStimulus(input logic [3:0] valid, input logic [63:0] data, input logic en);
    req_valid = valid;
    req_data  = data;
    enable    = en;
    #1;
  endtask

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    v0 = 4'b0000;
    d0 = 64'h0;
    reset = 1'b1;
    applyStimulus(4'b1111, 64'h1234_5678_9ABC_DEF0, 1'b1);
    tick;
    tick;
    $display("[TB] reset checks");
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_frame", 32'(frame), 32'h0);
    checkOutput("rst_busy",  32'(busy), 32'h0);
    checkOutput("rst_data",  32'(data_out), 32'h0);
    checkOutput("rst_first", 32'(first), 32'h0);
    reset = 1'b0;
    applyStimulus(4'b0000, 64'h0, 1'b1);
    tick;
    checkOutput("idle_busy",  32'(busy), 32'h0);
    checkOutput("idle_gid",   32'(grant_id), 32'h0);
    checkOutput("idle_ready", 32'(req_ready), 32'h0);

    $display("[TB] single request k=2 data A5C3");
    pat   = 16'hA5C3;
    dword = 64'h0000_A5C3_0000_0000;
    applyStimulus(4'b0100, dword, 1'b1);
    checkOutput("s1_ready", 32'(req_ready), 32'h4);
    tick;
    applyStimulus(4'b0000, dword, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("s1_frame", 32'(frame), 32'h1);
      checkOutput("s1_data",  32'(data_out), 32'(pat[15-i]));
      checkOutput("s1_first", 32'(first), 32'(i == 0));
      checkOutput("s1_gid",   32'(grant_id), 32'h2);
      tick;
    end
    checkOutput("s1_gap_frame", 32'(frame), 32'h0);
    checkOutput("s1_gap_data",  32'(data_out), 32'h0);
    checkOutput("s1_gap_busy",  32'(busy), 32'h1);
    tick;
    checkOutput("s1_idle_busy", 32'(busy), 32'h0);
    checkOutput("s1_idle_gid",  32'(grant_id), 32'h2);

    $display("[TB] round robin with all requesters valid");
    reset = 1'b1;
    applyStimulus(4'b0000, 64'h0, 1'b1);
    tick;
    reset = 1'b0;
    dword = 64'h1111_2222_3333_4444;
    applyStimulus(4'b1111, dword, 1'b1);
    for (int g = 0; g < 4; g++) begin
      checkOutput("rr_ready", 32'(req_ready), 32'(4'b0001 << g));
      tick;
      checkOutput("rr_gid",   32'(grant_id), 32'(g));
      checkOutput("rr_first", 32'(first), 32'h1);
      repeat (16) tick;
      checkOutput("rr_gap_ready", 32'(req_ready), 32'h0);
      checkOutput("rr_gap_busy",  32'(busy), 32'h1);
      tick;
    end
    checkOutput("rr_wrap_ready", 32'(req_ready), 32'h1);
    tick;
    checkOutput("rr_wrap_gid", 32'(grant_id), 32'h0);

    $display("[TB] requester 3 toggling outside idle");
    for (int j = 0; j < 16; j++) begin
      applyStimulus((j % 2 == 0) ? 4'b1000 : 4'b0000, dword, 1'b1);
      checkOutput("tg_shift_ready", 32'(req_ready), 32'h0);
      tick;
    end
    applyStimulus(4'b1000, dword, 1'b1);
    checkOutput("tg_gap_ready", 32'(req_ready), 32'h0);
    tick;
    applyStimulus(4'b0000, dword, 1'b1);
    checkOutput("tg_idle_ready", 32'(req_ready), 32'h0);
    checkOutput("tg_idle_busy",  32'(busy), 32'h0);
    tick;
    pat   = 16'h3C96;
    dword = 64'h0000_0000_3C96_0000;
    applyStimulus(4'b1011, dword, 1'b1);
    checkOutput("tg_ptr_ready", 32'(req_ready), 32'h2);

    $display("[TB] stall at bit 5");
    tick;
    applyStimulus(4'b0000, dword, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("st_data",  32'(data_out), 32'(pat[15-i]));
      checkOutput("st_frame", 32'(frame), 32'h1);
      tick;
    end
    applyStimulus(4'b0000, dword, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput("st_hold_data",  32'(data_out), 32'(pat[10]));
      checkOutput("st_hold_frame", 32'(frame), 32'h1);
      checkOutput("st_hold_first", 32'(first), 32'h0);
      tick;
    end
    applyStimulus(4'b0000, dword, 1'b1);
    for (int i = 5; i < 16; i++) begin
      checkOutput("st_data",  32'(data_out), 32'(pat[15-i]));
      checkOutput("st_frame", 32'(frame), 32'h1);
      tick;
    end
    checkOutput("st_end_frame", 32'(frame), 32'h0);
    checkOutput("st_end_busy",  32'(busy), 32'h1);
    tick;

    $display("[TB] reset in mid-frame");
    dword = 64'h0000_FFFF_8001_0000;
    applyStimulus(4'b0110, dword, 1'b1);
    checkOutput("rm_ready", 32'(req_ready), 32'h4);
    tick;
    applyStimulus(4'b0010, dword, 1'b1);
    repeat (7) tick;
    checkOutput("rm_bit7_frame", 32'(frame), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rm_rst_frame", 32'(frame), 32'h0);
    checkOutput("rm_rst_ready", 32'(req_ready), 32'h0);
    tick;
    checkOutput("rm_after_frame", 32'(frame), 32'h0);
    checkOutput("rm_after_data",  32'(data_out), 32'h0);
    checkOutput("rm_after_busy",  32'(busy), 32'h0);
    checkOutput("rm_after_gid",   32'(grant_id), 32'h0);
    reset = 1'b0;
    applyStimulus(4'b1010, dword, 1'b1);
    checkOutput("rm_regrant_ready", 32'(req_ready), 32'h2);
    tick;
    applyStimulus(4'b0000, dword, 1'b1);
    checkOutput("rm_regrant_gid",   32'(grant_id), 32'h1);
    checkOutput("rm_regrant_first", 32'(first), 32'h1);
    checkOutput("rm_regrant_data",  32'(data_out), 32'h1);

    $display("[TB] GAP=0 back-to-back frames");
    d0 = 64'h0000_0000_8000_0001;
    v0 = 4'b0011;
    #1;
    checkOutput("g0_ready0", 32'(ready0), 32'h1);
    tick;
    checkOutput("g0_first", 32'(first0), 32'h1);
    repeat (15) tick;
    checkOutput("g0_last_frame", 32'(frame0), 32'h1);
    checkOutput("g0_last_data",  32'(data0), 32'h1);
    tick;
    checkOutput("g0_idle_frame", 32'(frame0), 32'h0);
    checkOutput("g0_idle_busy",  32'(busy0), 32'h0);
    checkOutput("g0_idle_ready", 32'(ready0), 32'h2);
    tick;
    checkOutput("g0_second_first", 32'(first0), 32'h1);
    checkOutput("g0_second_gid",   32'(grant_id0), 32'h1);
    checkOutput("g0_second_data",  32'(data0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
